// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: major opcodes, ALU operation codes and immediate formats.
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: reassembles and sign-extends the RV32I immediate formats.
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_e'(imm_sel))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: register-file addressing, writeback bypass, control/immediate decode,
// load-use bubble insertion and a single output register toward EX.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [31:0]           if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic [REG_ADDR_W-1:0] read_reg_num1,
  output logic [REG_ADDR_W-1:0] read_reg_num2,
  input  logic [XLEN-1:0]       read_data1,
  input  logic [XLEN-1:0]       read_data2,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [XLEN-1:0]       wb_write_data,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_alusrc,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_regwrite,
  output logic                  ex_illegal,
  output logic [31:0]           stall_count
);

  function automatic logic [XLEN-1:0] sel_operand(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [XLEN-1:0]       rdata,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_reg,
    input logic [XLEN-1:0]       wb_data
  );
    if (idx == '0)                 return '0;
    else if (wb_we && wb_reg == idx) return wb_data;
    else                           return rdata;
  endfunction

  function automatic logic [3:0] alu_from_funct(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_reg
  );
    case (f3)
      3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]       rs1_val, rs2_val, dec_imm;
  logic [2:0]            dec_imm_sel;
  logic [3:0]            dec_alu_op;
  logic dec_alusrc, dec_memread, dec_memwrite, dec_branch, dec_jump, dec_regwrite, dec_illegal;
  logic uses_rs1, uses_rs2, hazard, accept;

  assign opcode        = if_instr[6:0];
  assign funct3        = if_instr[14:12];
  assign rd            = if_instr[11:7];
  assign rs1           = if_instr[19:15];
  assign rs2           = if_instr[24:20];
  assign read_reg_num1 = rs1;
  assign read_reg_num2 = rs2;

  assign rs1_val = sel_operand(rs1, read_data1, wb_regwrite, wb_write_reg, wb_write_data);
  assign rs2_val = sel_operand(rs2, read_data2, wb_regwrite, wb_write_reg, wb_write_data);

  always_comb begin
    dec_imm_sel  = IMM_NONE;
    dec_alu_op   = ALU_ADD;
    dec_alusrc   = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_regwrite = 1'b0;
    dec_illegal  = 1'b0;
    uses_rs1     = 1'b1;
    uses_rs2     = 1'b0;
    case (opcode)
      OPC_R: begin
        dec_alu_op   = alu_from_funct(funct3, if_instr[30], 1'b1);
        dec_regwrite = 1'b1;
        uses_rs2     = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_imm_sel  = IMM_I;
        dec_alu_op   = alu_from_funct(funct3, if_instr[30], 1'b0);
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm_sel  = IMM_I;
        dec_alusrc   = 1'b1;
        dec_memread  = 1'b1;
        dec_regwrite = 1'b1;
      end
      OPC_STORE: begin
        dec_imm_sel  = IMM_S;
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
        uses_rs2     = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm_sel = IMM_B;
        dec_alu_op  = ALU_SUB;
        dec_branch  = 1'b1;
        uses_rs2    = 1'b1;
      end
      OPC_JAL: begin
        dec_imm_sel  = IMM_J;
        dec_alusrc   = 1'b1;
        dec_jump     = 1'b1;
        dec_regwrite = 1'b1;
        uses_rs1     = 1'b0;
      end
      OPC_JALR: begin
        dec_imm_sel  = IMM_I;
        dec_alusrc   = 1'b1;
        dec_jump     = 1'b1;
        dec_regwrite = 1'b1;
      end
      OPC_LUI: begin
        dec_imm_sel  = IMM_U;
        dec_alu_op   = ALU_PASS;
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        uses_rs1     = 1'b0;
      end
      OPC_AUIPC: begin
        dec_imm_sel  = IMM_U;
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        uses_rs1     = 1'b0;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (if_instr[31:7]),
    .imm_sel (dec_imm_sel),
    .imm     (dec_imm)
  );

  // A bypassed operand still stalls: the load result is not yet on the writeback port.
  assign hazard = if_valid & ex_valid & ex_memread & (ex_rd != '0)
                & ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));
  assign if_ready = flush | ((~ex_valid | ex_ready) & ~hazard);
  assign accept   = if_valid & if_ready;

  // ---- decode -> EX output register ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_alu_op   <= '0;
      ex_alusrc   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_jump     <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_illegal  <= 1'b0;
      stall_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (hazard) begin
      if (ex_ready) begin
        ex_valid    <= 1'b0;
        stall_count <= sat_inc(stall_count);
      end
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_pc       <= if_pc;
      ex_imm      <= dec_imm;
      ex_rs1_data <= rs1_val;
      ex_rs2_data <= rs2_val;
      ex_rd       <= rd;
      ex_alu_op   <= ALU_OP_W'(dec_alu_op);
      ex_alusrc   <= dec_alusrc;
      ex_memread  <= dec_memread;
      ex_memwrite <= dec_memwrite;
      ex_branch   <= dec_branch;
      ex_jump     <= dec_jump;
      ex_regwrite <= dec_regwrite & (rd != '0);
      ex_illegal  <= dec_illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: reset, decode, bypass, immediates, load-use, hold, flush.
module tb_rv_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid, if_ready, flush, ex_valid, ex_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  read_reg_num1, read_reg_num2, wb_write_reg, ex_rd;
  logic [31:0] read_data1, read_data2, wb_write_data;
  logic        wb_regwrite;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, stall_count;
  logic [3:0]  ex_alu_op;
  logic        ex_alusrc, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_regwrite, ex_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rv_decode_stage dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .read_data1(read_data1), .read_data2(read_data2),
    .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alusrc(ex_alusrc),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal),
    .stall_count(stall_count)
  );

  localparam logic [31:0] ADD_X3  = 32'h002081B3;
  localparam logic [31:0] ADDI_X0 = 32'h00500013;
  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_X6  = 32'h00528333;
  localparam logic [31:0] ADDI_X4 = 32'h00700213;

  task automatic idle();
    if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; wb_regwrite = 1'b0;
    wb_write_reg = 5'd0; wb_write_data = 32'd0; read_data1 = 32'd0; read_data2 = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_instr = 32'd0; if_pc = 32'd0; idle();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    if_valid = 1'b1; if_instr = ADD_X3; if_pc = 32'h100; read_data1 = 32'd1; read_data2 = 32'd2;
    @(posedge clock); #2;
    reset = 1'b0; #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    checks++; if (ex_rs1_data !== 32'd0 || ex_rd !== 5'd0 || ex_pc !== 32'd0) begin errors++;
      $display("FAIL reset_data: rs1=%h rd=%0d pc=%h want 0", ex_rs1_data, ex_rd, ex_pc); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", ex_regwrite); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
    @(negedge clock);
    reset = 1'b1; idle();
    @(negedge clock);
  endtask

  task automatic test_add();
    if_valid = 1'b1; if_instr = ADD_X3; if_pc = 32'h200; read_data1 = 32'd1; read_data2 = 32'd2;
    #1;
    checks++; if (read_reg_num1 !== 5'd1 || read_reg_num2 !== 5'd2) begin errors++;
      $display("FAIL add_regnum: got %0d,%0d want 1,2", read_reg_num1, read_reg_num2); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", if_ready); end
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", ex_valid); end
    checks++; if (ex_rs1_data !== 32'd1 || ex_rs2_data !== 32'd2) begin errors++;
      $display("FAIL add_operands: got %h,%h want 1,2", ex_rs1_data, ex_rs2_data); end
    checks++; if (ex_rd !== 5'd3 || ex_regwrite !== 1'b1 || ex_illegal !== 1'b0) begin errors++;
      $display("FAIL add_ctrl: rd=%0d rw=%b ill=%b want 3,1,0", ex_rd, ex_regwrite, ex_illegal); end
    checks++; if (ex_alu_op !== 4'd0 || ex_alusrc !== 1'b0 || ex_pc !== 32'h200) begin errors++;
      $display("FAIL add_aluop: op=%0d src=%b pc=%h want 0,0,200", ex_alu_op, ex_alusrc, ex_pc); end
    @(negedge clock); idle();
    @(negedge clock);
  endtask

  task automatic test_bypass();
    if_valid = 1'b1; if_instr = ADD_X3; read_data1 = 32'd1; read_data2 = 32'd2;
    wb_regwrite = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'hDEAD;
    @(posedge clock); #1;
    checks++; if (ex_rs1_data !== 32'hDEAD || ex_rs2_data !== 32'd2) begin errors++;
      $display("FAIL bypass_rs1: got %h,%h want dead,2", ex_rs1_data, ex_rs2_data); end
    @(negedge clock);
    wb_regwrite = 1'b0; if_instr = ADDI_X0; read_data1 = 32'h55;
    @(posedge clock); #1;
    checks++; if (ex_rs1_data !== 32'd0) begin errors++; $display("FAIL x0_operand: got %h want 0", ex_rs1_data); end
    checks++; if (ex_regwrite !== 1'b0 || ex_imm !== 32'd5 || ex_alusrc !== 1'b1) begin errors++;
      $display("FAIL x0_ctrl: rw=%b imm=%h src=%b want 0,5,1", ex_regwrite, ex_imm, ex_alusrc); end
    @(negedge clock); idle();
    @(negedge clock);
  endtask

  task automatic test_imm();
    logic [31:0] instrs [4];
    logic [31:0] imms   [4];
    logic [3:0]  flags  [4];
    instrs[0] = 32'hFE20AE23; imms[0] = 32'hFFFFFFFC; flags[0] = 4'b0100; // sw x2,-4(x1)
    instrs[1] = 32'hFE208CE3; imms[1] = 32'hFFFFFFF8; flags[1] = 4'b0010; // beq x1,x2,-8
    instrs[2] = 32'h123453B7; imms[2] = 32'h12345000; flags[2] = 4'b1000; // lui x7,0x12345
    instrs[3] = 32'hFFDFF0EF; imms[3] = 32'hFFFFFFFC; flags[3] = 4'b1001; // jal x1,-4
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1; if_instr = instrs[i];
      @(posedge clock); #1;
      checks++; if (ex_imm !== imms[i]) begin errors++;
        $display("FAIL imm_%0d: got %h want %h", i, ex_imm, imms[i]); end
      checks++; if ({ex_regwrite, ex_memwrite, ex_branch, ex_jump} !== flags[i]) begin errors++;
        $display("FAIL ctrl_%0d: got %b want %b", i, {ex_regwrite, ex_memwrite, ex_branch, ex_jump}, flags[i]); end
      @(negedge clock);
    end
    idle();
    @(negedge clock);
  endtask

  task automatic test_load_use();
    if_valid = 1'b1; if_instr = LW_X5; read_data1 = 32'h100;
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b1 || ex_memread !== 1'b1 || ex_rd !== 5'd5) begin errors++;
      $display("FAIL lw_issue: v=%b mr=%b rd=%0d want 1,1,5", ex_valid, ex_memread, ex_rd); end
    @(negedge clock);
    if_instr = ADD_X6; #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready: got %b want 0", if_ready); end
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", ex_valid); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL bubble_count: got %0d want 1", stall_count); end
    @(negedge clock); #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_ready: got %b want 1", if_ready); end
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || stall_count !== 32'd1) begin errors++;
      $display("FAIL add_after_lw: v=%b rd=%0d cnt=%0d want 1,6,1", ex_valid, ex_rd, stall_count); end
    @(negedge clock); idle();
    @(negedge clock);
  endtask

  task automatic test_hold();
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = ADD_X3; read_data1 = 32'd1; read_data2 = 32'd2;
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3) begin errors++;
      $display("FAIL hold_load: v=%b rd=%0d want 1,3", ex_valid, ex_rd); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if_instr = ADDI_X4; read_data1 = 32'd9; #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d: got %b want 0", i, if_ready); end
      @(posedge clock); #1;
      checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_rs1_data !== 32'd1 || ex_rs2_data !== 32'd2) begin
        errors++; $display("FAIL hold_stable_%0d: v=%b rd=%0d rs1=%h rs2=%h want 1,3,1,2",
                           i, ex_valid, ex_rd, ex_rs1_data, ex_rs2_data); end
    end
    @(negedge clock);
    ex_ready = 1'b1; #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", if_ready); end
    @(posedge clock); #1;
    checks++; if (ex_rd !== 5'd4 || ex_imm !== 32'd7 || ex_rs1_data !== 32'd0) begin errors++;
      $display("FAIL release_load: rd=%0d imm=%h rs1=%h want 4,7,0", ex_rd, ex_imm, ex_rs1_data); end
    @(negedge clock); idle();
    @(negedge clock);
  endtask

  task automatic test_flush();
    if_valid = 1'b1; if_instr = ADD_X3;
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL preflush_valid: got %b want 1", ex_valid); end
    @(negedge clock);
    flush = 1'b1; ex_ready = 1'b0; if_instr = ADD_X6; #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", if_ready); end
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
    @(negedge clock);
    flush = 1'b0; ex_ready = 1'b1; if_instr = 32'hFFFFFFFF;
    @(posedge clock); #1;
    checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_regwrite !== 1'b0) begin errors++;
      $display("FAIL illegal: v=%b ill=%b rw=%b want 1,1,0", ex_valid, ex_illegal, ex_regwrite); end
    checks++; if (ex_memread !== 1'b0 || ex_memwrite !== 1'b0 || ex_branch !== 1'b0 || ex_jump !== 1'b0) begin
      errors++; $display("FAIL illegal_ctrl: mr=%b mw=%b br=%b j=%b want 0", ex_memread, ex_memwrite, ex_branch, ex_jump); end
    @(negedge clock); idle();
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_imm();
    test_load_use();
    test_hold();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
